// File: rtl/chi_par_pkg.sv
// rtl/chi_par_pkg.sv - shared types, constants and parity helper for the CHI parity monitor
package chi_par_pkg;

    // Widest flit the parity helper accepts; narrower flits are zero-extended by the caller.
    localparam int MAX_FLIT_W = 1024;
    localparam int MAX_NB     = MAX_FLIT_W / 8;

    // cap_type encoding
    localparam logic [1:0] CAP_DATA = 2'b01;
    localparam logic [1:0] CAP_CTRL = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CAPT = 1'b1
    } cap_state_t;

    // Expected odd-parity check bit per byte: 1 when the byte holds an even number of ones.
    // Zero-extended missing upper bits of a partial last byte therefore count as 0.
    function automatic logic [MAX_NB-1:0] byte_par_exp(input logic [MAX_FLIT_W-1:0] flit);
        logic [MAX_NB-1:0] r_exp;
        for (int i = 0; i < MAX_NB; i++) begin
            r_exp[i] = ~(^flit[i*8 +: 8]);
        end
        return r_exp;
    endfunction

endpackage

// File: rtl/chi_par_lane.sv
// rtl/chi_par_lane.sv - per-channel parity compare, error pulse, sticky flag and saturating counter
module chi_par_lane
    import chi_par_pkg::*;
#(
    parameter int FLIT_W = 128,
    parameter int NB     = (FLIT_W + 7) / 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_flitv,
    input  logic              i_flitv_chk,
    input  logic [FLIT_W-1:0] i_flit,
    input  logic [NB-1:0]     i_flit_chk,
    output logic              o_e,
    output logic              o_data_err,
    output logic              o_ctrl_err,
    output logic [NB-1:0]     o_bm,
    output logic              o_err_pulse,
    output logic              o_err_sticky,
    output logic [CNT_W-1:0]  o_err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [MAX_FLIT_W-1:0] w_flit_ext;
    logic [MAX_NB-1:0]     w_exp_full;
    logic [MAX_NB-1:0]     w_chk_ext;
    logic [MAX_NB-1:0]     w_mask;
    logic [MAX_NB-1:0]     w_bm_full;
    logic                  w_data_act;
    logic                  w_e;
    logic [CNT_W-1:0]      w_cnt_base;

    logic                  r_pulse;
    logic                  r_sticky;
    logic [CNT_W-1:0]      r_cnt;

    assign w_flit_ext = MAX_FLIT_W'(i_flit);
    assign w_exp_full = byte_par_exp(w_flit_ext);
    assign w_chk_ext  = MAX_NB'(i_flit_chk);
    assign w_mask     = MAX_NB'({NB{1'b1}});
    assign w_data_act = i_en & i_flitv;

    // Bytes beyond NB are masked off, so the full-width vector carries only real mismatches.
    assign w_bm_full  = (w_exp_full ^ w_chk_ext) & w_mask & {MAX_NB{w_data_act}};
    assign o_data_err = |w_bm_full;
    assign o_bm       = w_bm_full[NB-1:0];
    assign o_ctrl_err = i_en & (i_flitv_chk == i_flitv);
    assign w_e        = o_data_err | o_ctrl_err;
    assign o_e        = w_e;

    // A clear in the same cycle as an error wipes the old count first, then counts the new error.
    assign w_cnt_base = i_clr ? '0 : r_cnt;

    // Registered error pulse, sticky flag and saturating counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pulse  <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_pulse  <= w_e;
            r_sticky <= (r_sticky & ~i_clr) | w_e;
            if (w_e && (w_cnt_base != CNT_MAX)) begin
                r_cnt <= w_cnt_base + CNT_W'(1);
            end else begin
                r_cnt <= w_cnt_base;
            end
        end
    end

    assign o_err_pulse  = r_pulse;
    assign o_err_sticky = r_sticky;
    assign o_err_cnt    = r_cnt;

endmodule

// File: rtl/chi_par_monitor.sv
// rtl/chi_par_monitor.sv - multi-channel CHI flit parity monitor with first-error capture
module chi_par_monitor
    import chi_par_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int FLIT_W = 128,
    parameter int CNT_W  = 16,
    parameter int NB     = (FLIT_W + 7) / 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic [NUM_CH-1:0]        i_flitv,
    input  logic [NUM_CH-1:0]        i_flitv_chk,
    input  logic [NUM_CH*FLIT_W-1:0] i_flit,
    input  logic [NUM_CH*NB-1:0]     i_flit_chk,
    output logic [NUM_CH-1:0]        o_err_pulse,
    output logic [NUM_CH-1:0]        o_err_sticky,
    output logic [NUM_CH*CNT_W-1:0]  o_err_cnt,
    output logic                     o_cap_vld,
    output logic [CH_W-1:0]          o_cap_ch,
    output logic [1:0]               o_cap_type,
    output logic [NB-1:0]            o_cap_byte
);

    logic [NUM_CH-1:0]    w_e;
    logic [NUM_CH-1:0]    w_data_err;
    logic [NUM_CH-1:0]    w_ctrl_err;
    logic [NUM_CH*NB-1:0] w_bm;

    logic [CH_W-1:0]      w_sel_ch;
    logic [1:0]           w_sel_type;
    logic [NB-1:0]        w_sel_byte;

    cap_state_t           r_state;
    cap_state_t           w_state_nxt;
    logic [CH_W-1:0]      r_cap_ch;
    logic [CH_W-1:0]      w_cap_ch_nxt;
    logic [1:0]           r_cap_type;
    logic [1:0]           w_cap_type_nxt;
    logic [NB-1:0]        r_cap_byte;
    logic [NB-1:0]        w_cap_byte_nxt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        chi_par_lane #(
            .FLIT_W (FLIT_W),
            .NB     (NB),
            .CNT_W  (CNT_W)
        ) u_lane (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_en         (i_en),
            .i_clr        (i_clr),
            .i_flitv      (i_flitv[c]),
            .i_flitv_chk  (i_flitv_chk[c]),
            .i_flit       (i_flit[c*FLIT_W +: FLIT_W]),
            .i_flit_chk   (i_flit_chk[c*NB +: NB]),
            .o_e          (w_e[c]),
            .o_data_err   (w_data_err[c]),
            .o_ctrl_err   (w_ctrl_err[c]),
            .o_bm         (w_bm[c*NB +: NB]),
            .o_err_pulse  (o_err_pulse[c]),
            .o_err_sticky (o_err_sticky[c]),
            .o_err_cnt    (o_err_cnt[c*CNT_W +: CNT_W])
        );
    end

    // Lowest-index erroring channel wins; scanning downwards lets the lowest index overwrite last.
    always_comb begin
        w_sel_ch   = '0;
        w_sel_type = 2'b00;
        w_sel_byte = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_e[c]) begin
                w_sel_ch   = CH_W'(c);
                w_sel_type = (w_data_err[c] ? CAP_DATA : 2'b00) |
                             (w_ctrl_err[c] ? CAP_CTRL : 2'b00);
                w_sel_byte = w_bm[c*NB +: NB];
            end
        end
    end

    // Capture next state: clear takes effect first, then a pending error may be recorded.
    always_comb begin
        w_state_nxt    = r_state;
        w_cap_ch_nxt   = r_cap_ch;
        w_cap_type_nxt = r_cap_type;
        w_cap_byte_nxt = r_cap_byte;
        if (i_clr) begin
            w_state_nxt    = ST_IDLE;
            w_cap_ch_nxt   = '0;
            w_cap_type_nxt = 2'b00;
            w_cap_byte_nxt = '0;
        end
        if ((i_clr || (r_state == ST_IDLE)) && (|w_e)) begin
            w_state_nxt    = ST_CAPT;
            w_cap_ch_nxt   = w_sel_ch;
            w_cap_type_nxt = w_sel_type;
            w_cap_byte_nxt = w_sel_byte;
        end
    end

    // Capture state and record registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cap_ch   <= '0;
            r_cap_type <= 2'b00;
            r_cap_byte <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cap_ch   <= w_cap_ch_nxt;
            r_cap_type <= w_cap_type_nxt;
            r_cap_byte <= w_cap_byte_nxt;
        end
    end

    assign o_cap_vld  = (r_state == ST_CAPT);
    assign o_cap_ch   = r_cap_ch;
    assign o_cap_type = r_cap_type;
    assign o_cap_byte = r_cap_byte;

endmodule

// File: tb/tb_chi_par_monitor.sv
// tb/tb_chi_par_monitor.sv - scoreboard testbench for chi_par_monitor
module tb_chi_par_monitor;

    typedef struct packed {
        logic [3:0]  pulse;
        logic [3:0]  sticky;
        logic [63:0] cnt;
        logic        vld;
        logic [1:0]  ch;
        logic [1:0]  typ;
        logic [15:0] byt;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4 x 128-bit flits, 4-bit counters
    logic         a_rst, a_en, a_clr;
    logic [3:0]   a_flitv, a_flitv_chk;
    logic [511:0] a_flit;
    logic [63:0]  a_flit_chk;
    logic [3:0]   a_pulse, a_sticky;
    logic [15:0]  a_cnt;
    logic         a_vld;
    logic [1:0]   a_ch, a_type;
    logic [15:0]  a_byte;

    // DUT B: 4 x 20-bit flits (partial last byte), 16-bit counters
    logic         b_rst, b_en, b_clr;
    logic [3:0]   b_flitv, b_flitv_chk;
    logic [79:0]  b_flit;
    logic [11:0]  b_flit_chk;
    logic [3:0]   b_pulse, b_sticky;
    logic [63:0]  b_cnt;
    logic         b_vld;
    logic [1:0]   b_ch, b_type;
    logic [2:0]   b_byte;

    chi_par_monitor #(.NUM_CH(4), .FLIT_W(128), .CNT_W(4)) u_dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_en(a_en), .i_clr(a_clr),
        .i_flitv(a_flitv), .i_flitv_chk(a_flitv_chk), .i_flit(a_flit), .i_flit_chk(a_flit_chk),
        .o_err_pulse(a_pulse), .o_err_sticky(a_sticky), .o_err_cnt(a_cnt),
        .o_cap_vld(a_vld), .o_cap_ch(a_ch), .o_cap_type(a_type), .o_cap_byte(a_byte)
    );

    chi_par_monitor #(.NUM_CH(4), .FLIT_W(20), .CNT_W(16)) u_dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_clr(b_clr),
        .i_flitv(b_flitv), .i_flitv_chk(b_flitv_chk), .i_flit(b_flit), .i_flit_chk(b_flit_chk),
        .o_err_pulse(b_pulse), .o_err_sticky(b_sticky), .o_err_cnt(b_cnt),
        .o_cap_vld(b_vld), .o_cap_ch(b_ch), .o_cap_type(b_type), .o_cap_byte(b_byte)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    res_t sb_a[$];
    res_t sb_b[$];
    res_t ex, ob;

    // reference model state for DUT A
    logic [3:0]  m_sticky;
    logic [3:0]  m_cnt [4];
    logic        m_vld;
    logic [1:0]  m_ch, m_ty;
    logic [15:0] m_byte;

    function automatic logic [15:0] good_chk(input logic [127:0] f);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = ($countones(f[i*8 +: 8]) % 2 == 0);
        return r;
    endfunction

    function automatic res_t obs_a();
        res_t r;
        r.pulse = a_pulse; r.sticky = a_sticky; r.cnt = {48'b0, a_cnt};
        r.vld = a_vld; r.ch = a_ch; r.typ = a_type; r.byt = a_byte;
        return r;
    endfunction

    function automatic res_t obs_b();
        res_t r;
        r.pulse = b_pulse; r.sticky = b_sticky; r.cnt = b_cnt;
        r.vld = b_vld; r.ch = b_ch; r.typ = b_type; r.byt = {13'b0, b_byte};
        return r;
    endfunction

    function automatic res_t mk(input logic [3:0] p, input logic [3:0] s, input logic [63:0] c,
                                input logic v, input logic [1:0] ch, input logic [1:0] t,
                                input logic [15:0] b);
        res_t r;
        r.pulse = p; r.sticky = s; r.cnt = c; r.vld = v; r.ch = ch; r.typ = t; r.byt = b;
        return r;
    endfunction

    // Predict DUT A outputs one cycle after the currently driven inputs and queue them.
    task automatic model_a();
        logic [3:0]  e;
        logic [15:0] bm [4];
        logic [1:0]  ty [4];
        logic        ctl;
        for (int c = 0; c < 4; c++) begin
            bm[c] = 16'h0;
            if (a_en && a_flitv[c]) bm[c] = good_chk(a_flit[c*128 +: 128]) ^ a_flit_chk[c*16 +: 16];
            ctl   = a_en && (a_flitv_chk[c] == a_flitv[c]);
            ty[c] = {ctl, (bm[c] != 16'h0)};
            e[c]  = ctl || (bm[c] != 16'h0);
        end
        if (a_rst) begin
            e = 4'h0; m_sticky = 4'h0; m_vld = 1'b0; m_ch = 2'd0; m_ty = 2'd0; m_byte = 16'h0;
            for (int c = 0; c < 4; c++) m_cnt[c] = 4'h0;
        end else begin
            if (a_clr) begin
                m_sticky = 4'h0; m_vld = 1'b0; m_ch = 2'd0; m_ty = 2'd0; m_byte = 16'h0;
                for (int c = 0; c < 4; c++) m_cnt[c] = 4'h0;
            end
            m_sticky = m_sticky | e;
            for (int c = 0; c < 4; c++) if (e[c] && m_cnt[c] != 4'hF) m_cnt[c] = m_cnt[c] + 4'h1;
            if (!m_vld && e != 4'h0) begin
                m_vld = 1'b1;
                for (int c = 3; c >= 0; c--) begin
                    if (e[c]) begin m_ch = 2'(c); m_ty = ty[c]; m_byte = bm[c]; end
                end
            end
        end
        sb_a.push_back(mk(e, m_sticky, {48'b0, m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]},
                          m_vld, m_ch, m_ty, m_byte));
    endtask

    task automatic set_clean_a();
        a_rst = 1'b0; a_en = 1'b1; a_clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            a_flit[c*128 +: 128]    = {$urandom, $urandom, $urandom, $urandom};
            a_flitv[c]              = 1'($urandom_range(0, 1));
            a_flitv_chk[c]          = ~a_flitv[c];
            a_flit_chk[c*16 +: 16]  = good_chk(a_flit[c*128 +: 128]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cycle_a();
        set_clean_a();
        a_clr = 1'b1;
        model_a();
        tick();
        ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL clr_cycle: got %h expected %h", ob, ex); end
        a_clr = 1'b0;
    endtask

    task automatic test_reset();
        set_clean_a();
        a_rst = 1'b1;
        b_rst = 1'b1; b_en = 1'b1; b_clr = 1'b0;
        b_flitv = 4'h0; b_flitv_chk = 4'hF; b_flit = '0; b_flit_chk = '1;
        for (int i = 0; i < 2; i++) begin
            model_a();
            sb_b.push_back(mk(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 2'd0, 16'h0));
            tick();
            ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
            if (ob !== ex) begin n_err++; $display("FAIL reset_a: got %h expected %h", ob, ex); end
            ex = sb_b.pop_front(); ob = obs_b(); n_checks++;
            if (ob !== ex) begin n_err++; $display("FAIL reset_b: got %h expected %h", ob, ex); end
        end
        a_rst = 1'b0; b_rst = 1'b0;
    endtask

    task automatic test_clean();
        for (int i = 0; i < 100; i++) begin
            set_clean_a();
            model_a();
            tick();
            ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
            if (ob !== ex) begin n_err++; $display("FAIL clean[%0d]: got %h expected %h", i, ob, ex); end
        end
        n_checks++;
        if (a_sticky !== 4'h0 || a_cnt !== 16'h0 || a_vld !== 1'b0) begin
            n_err++; $display("FAIL clean_final: sticky %h cnt %h vld %b required 0", a_sticky, a_cnt, a_vld);
        end
    endtask

    task automatic test_single_byte();
        clr_cycle_a();
        set_clean_a();
        a_flitv[2] = 1'b1; a_flitv_chk[2] = 1'b0;
        a_flit[2*128 +: 128] = '0;
        a_flit_chk[2*16 +: 16] = 16'hFFDF;
        model_a();
        tick();
        ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL single_byte: got %h expected %h", ob, ex); end
        n_checks++;
        if (a_pulse !== 4'b0100 || a_ch !== 2'd2 || a_type !== 2'b01 || a_byte !== 16'h0020 || a_cnt[11:8] !== 4'd1) begin
            n_err++;
            $display("FAIL single_byte_fields: pulse %b ch %0d type %b byte %h cnt2 %0d required 0100 2 01 0020 1",
                     a_pulse, a_ch, a_type, a_byte, a_cnt[11:8]);
        end
        set_clean_a();
        model_a();
        tick();
        ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL single_byte_after: got %h expected %h", ob, ex); end
        n_checks++;
        if (a_pulse !== 4'b0000) begin n_err++; $display("FAIL single_byte_deassert: pulse %b required 0000", a_pulse); end
    endtask

    task automatic test_ctrl_err();
        clr_cycle_a();
        for (int i = 0; i < 3; i++) begin
            set_clean_a();
            a_flitv[0] = 1'b0; a_flitv_chk[0] = 1'b0;
            model_a();
            tick();
            ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
            if (ob !== ex) begin n_err++; $display("FAIL ctrl_err[%0d]: got %h expected %h", i, ob, ex); end
        end
        n_checks++;
        if (a_cnt[3:0] !== 4'd3 || a_type !== 2'b10 || a_byte !== 16'h0 || a_ch !== 2'd0 || a_vld !== 1'b1) begin
            n_err++;
            $display("FAIL ctrl_err_fields: cnt0 %0d type %b byte %h ch %0d vld %b required 3 10 0000 0 1",
                     a_cnt[3:0], a_type, a_byte, a_ch, a_vld);
        end
    endtask

    task automatic test_simul();
        clr_cycle_a();
        set_clean_a();
        a_flitv[1] = 1'b1; a_flitv_chk[1] = 1'b0;
        a_flit_chk[1*16 +: 16] = good_chk(a_flit[1*128 +: 128]) ^ 16'h0008;
        a_flitv_chk[3] = a_flitv[3];
        model_a();
        tick();
        ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL simul: got %h expected %h", ob, ex); end
        n_checks++;
        if (a_ch !== 2'd1 || a_cnt[7:4] !== 4'd1 || a_cnt[15:12] !== 4'd1) begin
            n_err++; $display("FAIL simul_fields: ch %0d cnt1 %0d cnt3 %0d required 1 1 1", a_ch, a_cnt[7:4], a_cnt[15:12]);
        end
        set_clean_a();
        a_flitv_chk[0] = a_flitv[0];
        model_a();
        tick();
        ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL simul_follow: got %h expected %h", ob, ex); end
        n_checks++;
        if (a_ch !== 2'd1 || a_type !== 2'b01 || a_byte !== 16'h0008) begin
            n_err++; $display("FAIL simul_hold: ch %0d type %b byte %h required 1 01 0008", a_ch, a_type, a_byte);
        end
    endtask

    task automatic test_sat_clear();
        clr_cycle_a();
        for (int i = 0; i < 20; i++) begin
            set_clean_a();
            a_flitv[0] = 1'b0; a_flitv_chk[0] = 1'b0;
            model_a();
            tick();
            ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
            if (ob !== ex) begin n_err++; $display("FAIL sat[%0d]: got %h expected %h", i, ob, ex); end
        end
        n_checks++;
        if (a_cnt[3:0] !== 4'd15) begin n_err++; $display("FAIL sat_value: cnt0 %0d required 15", a_cnt[3:0]); end
        set_clean_a();
        a_clr = 1'b1;
        a_flitv[0] = 1'b1; a_flitv_chk[0] = 1'b0;
        a_flit_chk[0 +: 16] = good_chk(a_flit[0 +: 128]) ^ 16'h0001;
        model_a();
        tick();
        ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL clr_and_err: got %h expected %h", ob, ex); end
        n_checks++;
        if (a_cnt[3:0] !== 4'd1 || a_sticky[0] !== 1'b1 || a_vld !== 1'b1 || a_type !== 2'b01 || a_byte !== 16'h0001) begin
            n_err++;
            $display("FAIL clr_and_err_fields: cnt0 %0d sticky0 %b vld %b type %b byte %h required 1 1 1 01 0001",
                     a_cnt[3:0], a_sticky[0], a_vld, a_type, a_byte);
        end
        a_clr = 1'b0;
    endtask

    task automatic test_enable();
        for (int i = 0; i < 2; i++) begin
            set_clean_a();
            a_en = 1'b0;
            a_flitv_chk = a_flitv;
            a_flit_chk = ~a_flit_chk;
            model_a();
            tick();
            ex = sb_a.pop_front(); ob = obs_a(); n_checks++;
            if (ob !== ex) begin n_err++; $display("FAIL enable_off[%0d]: got %h expected %h", i, ob, ex); end
        end
        n_checks++;
        if (a_pulse !== 4'h0 || a_cnt[3:0] !== 4'd1) begin
            n_err++; $display("FAIL enable_hold: pulse %b cnt0 %0d required 0000 1", a_pulse, a_cnt[3:0]);
        end
    endtask

    task automatic test_partial_en_rst();
        b_rst = 1'b0; b_clr = 1'b0; b_en = 1'b1;
        b_flitv = 4'b0001; b_flitv_chk = 4'b1110;
        b_flit = '0; b_flit[19:0] = 20'hF0000;
        b_flit_chk = '1;
        sb_b.push_back(mk(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 2'd0, 16'h0));
        tick();
        ex = sb_b.pop_front(); ob = obs_b(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL partial_ok: got %h expected %h", ob, ex); end

        b_en = 1'b0; b_flit_chk[2:0] = 3'b011; b_flitv_chk[0] = 1'b1;
        sb_b.push_back(mk(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 2'd0, 16'h0));
        tick();
        ex = sb_b.pop_front(); ob = obs_b(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL partial_en_off: got %h expected %h", ob, ex); end

        b_en = 1'b1; b_flitv_chk[0] = 1'b0;
        sb_b.push_back(mk(4'b0001, 4'b0001, 64'h1, 1'b1, 2'd0, 2'b01, 16'h0004));
        tick();
        ex = sb_b.pop_front(); ob = obs_b(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL partial_bad: got %h expected %h", ob, ex); end

        b_rst = 1'b1;
        sb_b.push_back(mk(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 2'd0, 16'h0));
        tick();
        ex = sb_b.pop_front(); ob = obs_b(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL mid_reset: got %h expected %h", ob, ex); end

        b_rst = 1'b0; b_flit_chk = '1;
        sb_b.push_back(mk(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 2'd0, 16'h0));
        tick();
        ex = sb_b.pop_front(); ob = obs_b(); n_checks++;
        if (ob !== ex) begin n_err++; $display("FAIL after_reset: got %h expected %h", ob, ex); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_byte();
        test_ctrl_err();
        test_simul();
        test_sat_clear();
        test_enable();
        test_partial_en_rst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/chi_par_monitor.md
Name: chi_par_monitor

Overview:
- Clocked, multi-channel CHI flit parity checker for the receive side of a CHI link.
- Checks per-byte odd parity on flits and inverted-copy check bits on flitv, one checker per channel.
- Reports errors per channel: one-cycle pulses, sticky flags, saturating counters, and a first-error capture record.
- Sits between the CHI interface signals and the TB scoreboard/error logger; it does not modify or stall traffic.

Parameters:
- NUM_CH, 4, number of monitored channels (e.g. RXREQ/RXRSP/RXDAT/RXSNP).
- FLIT_W, 128, flit width in bits, identical for all channels; NB = (FLIT_W+7)/8 check bits per flit.
- CNT_W, 16, width of each per-channel error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  checking enable; when 0, no error is detected or recorded.
- clr  in  1  one-cycle pulse; clears sticky flags, counters and capture.
- flitv  in  NUM_CH  flit valid per channel.
- flitv_chk  in  NUM_CH  check bit for flitv (expected ~flitv).
- flit  in  NUM_CH*FLIT_W  flits; channel c occupies [c*FLIT_W +: FLIT_W].
- flit_chk  in  NUM_CH*NB  byte parity; channel c occupies [c*NB +: NB].
- err_pulse  out  NUM_CH  one-cycle error indication per channel.
- err_sticky  out  NUM_CH  sticky error flag per channel.
- err_cnt  out  NUM_CH*CNT_W  saturating error count per channel.
- cap_vld  out  1  first-error record is valid.
- cap_ch  out  $clog2(NUM_CH) (min 1)  channel index of the first error.
- cap_type  out  2  bit0 = data parity error, bit1 = flitv check error.
- cap_byte  out  NB  mask of failing bytes in the first error.

Behaviour:
- Reset: all outputs are 0. cap_ch = 0.
- Byte parity rule: expected chk[i] = 1 when countones(byte i) is even, so byte plus check bit has odd ones.
- Last partial byte (FLIT_W%8 != 0): missing upper bits count as 0.
- Data check applies only in cycles with flitv[c]=1 and en=1.
  - Byte mismatch mask bm[c] = expected ^ flit_chk, over NB bits.
  - Data error when bm[c] is non-zero.
- Control check applies every cycle with en=1.
  - Control error when flitv_chk[c] == flitv[c].
- Channel error e[c] = data error | control error.
- Latency: inputs in cycle t give err_pulse[c]=e[c] in cycle t+1, through one register stage.
  - err_pulse deasserts in t+2 unless a new error occurs.
- err_sticky[c] sets at the same edge as err_pulse and holds until clr or rst.
- err_cnt[c] increments by 1 per error cycle and saturates at 2^CNT_W-1 (no wrap).
  - Multiple bad bytes in one flit count as 1.
- Capture FSM, per monitor, two states:
  - IDLE: on any e[c], record the lowest-index erroring channel, its cap_type and its cap_byte, then go to CAPT.
    - cap_byte = 0 when the error is control-only.
  - CAPT: cap_vld=1 and fields are frozen; later errors do not overwrite them.
  - clr in CAPT returns to IDLE, clearing cap_vld and the fields.
- Simultaneous clr and error in the same cycle: clear first, then record the new error.
  - Result next cycle: sticky=1, cnt=1, FSM=CAPT holding the new error.
- clr does not affect err_pulse.
- en=0: no new detection. Existing sticky flags, counts and capture hold.
  - err_pulse is 0 in the next cycle.
- rst mid-operation: all state returns to reset values at that edge; inputs in the rst cycle are ignored.
- X/Z on inputs: no requirement; the TB drives known values.

Decomposition:
- Package chi_par_pkg:
  - function byte_par_exp(flit) returning NB expected check bits.
  - localparam CAP_DATA=2'b01, CAP_CTRL=2'b10.
- Sub-module chi_par_lane, instantiated NUM_CH times:
  - combinational parity/compare.
  - registered err_pulse, sticky and saturating counter.
  - outputs e and bm to the top.
- The top holds the capture FSM and the lowest-index priority encoder.

Test Plan:
- Clean traffic: 100 random flits on all 4 channels with correct parity -> err_pulse/err_sticky/err_cnt all 0, cap_vld=0.
- Single byte error: ch2 flit 0x00..00 with flit_chk[5]=0 (expected 1) in cycle t -> err_pulse=4'b0100 in t+1 only; err_cnt[2]=1; cap_ch=2, cap_type=01, cap_byte=16'h0020.
- Control error, no flit: ch0 flitv=0, flitv_chk=0 -> cap_type=10, cap_byte=0.
  - Same fault held for 3 cycles -> err_cnt[0]=3, capture unchanged after the first cycle.
- Simultaneous errors: ch1 and ch3 fail in the same cycle -> cap_ch=1; both counters = 1.
  - Follow-on ch0 error -> capture stays on ch1.
- Saturation and clear (CNT_W=4): 20 error cycles on ch0 -> err_cnt[0]=15.
  - clr pulse together with a ch0 error -> next cycle err_cnt[0]=1, sticky=1, cap_vld=1 with the new record.
- Partial byte and enable (FLIT_W=20, NB=3): top nibble 0xF with chk[2]=1 -> no error.
  - en=0 with a bad chk on the same flit -> no error.
  - rst asserted mid-run -> all outputs 0 the next cycle.
